// File: rtl/layer_compositor_if.sv
// Pixel-stream bundle between sprite layers and the compositor output stage.
// master drives layer/video inputs; slave is the compositor.
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 4
);
    localparam int NPAIR = NUM_LAYERS * (NUM_LAYERS - 1) / 2;

    logic                     fsync;
    logic                     de_in;
    logic [NUM_LAYERS-1:0]    layer_active;
    logic [NUM_LAYERS*24-1:0] layer_rgb;
    logic                     override_en;
    logic [23:0]              override_rgb;
    logic [23:0]              pixel_out;
    logic                     de_out;
    logic [NPAIR-1:0]         hit_flags;
    logic                     hit_valid;
    logic                     any_hit;

    modport master (
        output fsync, de_in, layer_active, layer_rgb, override_en, override_rgb,
        input  pixel_out, de_out, hit_flags, hit_valid, any_hit
    );

    modport slave (
        input  fsync, de_in, layer_active, layer_rgb, override_en, override_rgb,
        output pixel_out, de_out, hit_flags, hit_valid, any_hit
    );
endinterface

// File: rtl/layer_compositor.sv
// N-layer pixel compositor (priority or OR mix) with a 2-cycle pipeline,
// plus a per-frame pairwise collision detector latched on fsync.
module layer_compositor #(
    parameter int                                      NUM_LAYERS = 4,
    parameter int                                      MIX_MODE   = 0,
    parameter logic [23:0]                             BG_RGB     = 24'h000000,
    parameter logic [NUM_LAYERS*(NUM_LAYERS-1)/2-1:0]  PAIR_MASK  = '1
) (
    input  logic               pixel_clk,
    input  logic               rst,
    layer_compositor_if.slave  bus
);
    localparam int NPAIR = NUM_LAYERS * (NUM_LAYERS - 1) / 2;

    logic                     de_reg;
    logic                     override_en_reg;
    logic [23:0]              override_rgb_reg;
    logic [NUM_LAYERS-1:0]    active_reg;
    logic [NUM_LAYERS*24-1:0] rgb_reg;

    logic [23:0]              pixel_out_reg;
    logic                     de_out_reg;
    logic [23:0]              pixel_next;
    logic [23:0]              mix_rgb;
    logic [23:0]              masked_rgb [NUM_LAYERS];

    logic [NPAIR-1:0]         pair_hit;
    logic [NPAIR-1:0]         hit_now;
    logic [NPAIR-1:0]         accum_reg;
    logic [NPAIR-1:0]         latch_next;
    logic [NPAIR-1:0]         hit_flags_reg;
    logic                     hit_valid_reg;
    logic                     any_hit_reg;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            de_reg           <= 1'b0;
            override_en_reg  <= 1'b0;
            override_rgb_reg <= '0;
            active_reg       <= '0;
            rgb_reg          <= '0;
        end else begin
            de_reg           <= bus.de_in;
            override_en_reg  <= bus.override_en;
            override_rgb_reg <= bus.override_rgb;
            active_reg       <= bus.layer_active;
            rgb_reg          <= bus.layer_rgb;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_mask
            assign masked_rgb[gi] = active_reg[gi] ? rgb_reg[24*gi +: 24] : 24'h000000;
        end
    endgenerate

    // Priority mode scans from the highest index down so the lowest active index wins.
    always_comb begin
        mix_rgb = '0;
        if (MIX_MODE == 1) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                mix_rgb = mix_rgb | masked_rgb[i];
            end
        end else begin
            for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
                if (active_reg[i]) begin
                    mix_rgb = masked_rgb[i];
                end
            end
        end
    end

    always_comb begin
        pixel_next = '0;
        if (!de_reg) begin
            pixel_next = '0;
        end else if (override_en_reg) begin
            pixel_next = override_rgb_reg;
        end else if (|active_reg) begin
            pixel_next = mix_rgb;
        end else begin
            pixel_next = BG_RGB;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            pixel_out_reg <= '0;
            de_out_reg    <= 1'b0;
        end else begin
            pixel_out_reg <= pixel_next;
            de_out_reg    <= de_reg;
        end
    end

    // Pair k for (i,j), i<j, enumerated row by row: (0,1),(0,2)..(1,2)..
    generate
        for (genvar gi = 0; gi < NUM_LAYERS - 1; gi++) begin : g_row
            for (genvar gj = gi + 1; gj < NUM_LAYERS; gj++) begin : g_col
                localparam int K = gi * NUM_LAYERS - gi * (gi + 1) / 2 + gj - gi - 1;
                assign pair_hit[K] = bus.layer_active[gi] & bus.layer_active[gj];
            end
        end
    endgenerate

    assign hit_now    = bus.de_in ? (pair_hit & PAIR_MASK) : '0;
    assign latch_next = accum_reg | hit_now;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            accum_reg     <= '0;
            hit_flags_reg <= '0;
            hit_valid_reg <= 1'b0;
            any_hit_reg   <= 1'b0;
        end else if (bus.fsync) begin
            accum_reg     <= '0;
            hit_flags_reg <= latch_next;
            hit_valid_reg <= 1'b1;
            any_hit_reg   <= |latch_next;
        end else begin
            accum_reg     <= latch_next;
            hit_valid_reg <= 1'b0;
        end
    end

    assign bus.pixel_out = pixel_out_reg;
    assign bus.de_out    = de_out_reg;
    assign bus.hit_flags = hit_flags_reg;
    assign bus.hit_valid = hit_valid_reg;
    assign bus.any_hit   = any_hit_reg;
endmodule
